sb_edge_cfg_chain: RTL and testbench

Parametrised corner switch block for the FPGA routing fabric, CHAN_W tracks per side. Routes the top channel and the left channel through 4:1 output muxes. Mux selects come from a shadowed configuration chain: bits shift in on ccff_head while the muxes keep their old selects, then apply atomically on a commit strobe. A shift counter reports chain-full and flags a commit of a partially loaded chain.

---
 rtl/sb_cfg_pkg.sv | 35 +++
 rtl/sb_cfg_chain.sv | 72 +++++++
 rtl/sb_edge_cfg_chain.sv | 63 ++++++
 tb/tb_sb_edge_cfg_chain.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_cfg_pkg.sv
// Shared select encodings and index helpers for the corner switch block.
package sb_cfg_pkg;

    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_OFF      = 2'b00;
    localparam logic [SEL_W-1:0] SEL_PIN      = 2'b01;
    localparam logic [SEL_W-1:0] SEL_TWIST    = 2'b10;
    localparam logic [SEL_W-1:0] SEL_STRAIGHT = 2'b11;

    // Twisted track index: track 0 maps to itself, others mirror across the channel.
    function automatic int unsigned tw(input int unsigned i, input int unsigned w);
        return (i == 0) ? 0 : (w - i);
    endfunction

    // Chain length for a channel of w tracks: two sides, SEL_W bits per mux.
    function automatic int unsigned chain_len(input int unsigned w);
        return 2 * w * SEL_W;
    endfunction

    // 4:1 track mux.
    function automatic logic mux4(input logic [SEL_W-1:0] sel, input logic pin,
                                  input logic twist, input logic straight);
        logic y;
        y = 1'b0;
        case (sel)
            SEL_PIN:      y = pin;
            SEL_TWIST:    y = twist;
            SEL_STRAIGHT: y = straight;
            default:      y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/sb_cfg_chain.sv
// Serial configuration chain with shadow register and fill counter.
module sb_cfg_chain
    import sb_cfg_pkg::*;
#(
    parameter int unsigned CHAIN_L = 36
) (
    input  logic               prog_clk,
    input  logic               prog_reset,
    input  logic               ccff_head,
    input  logic               ccff_en,
    input  logic               cfg_commit,
    output logic [CHAIN_L-1:0] sh,
    output logic               ccff_tail,
    output logic               cfg_ready,
    output logic               cfg_err
);

    localparam int unsigned          CNT_W    = $clog2(CHAIN_L + 1);
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(CHAIN_L);

    logic [CHAIN_L-1:0] sr;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               cnt_full;

    assign cnt_full  = (cnt == CNT_FULL);
    assign ccff_tail = sr[CHAIN_L-1];

    // Next fill count: commit restarts the count, counting the shift of the same edge.
    always_comb begin
        cnt_nxt = cnt;
        if (cfg_commit) begin
            cnt_nxt = ccff_en ? CNT_W'(1) : '0;
        end else if (ccff_en && !cnt_full) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Shift chain: newest bit enters at sr[0].
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            sr <= '0;
        end else if (ccff_en) begin
            sr <= {sr[CHAIN_L-2:0], ccff_head};
        end
    end

    // Shadow captures the pre-edge chain so the muxes switch atomically.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            sh <= '0;
        end else if (cfg_commit) begin
            sh <= sr;
        end
    end

    // Fill counter, ready flag and sticky partial-commit error.
    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            cnt       <= '0;
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            cfg_ready <= (cnt_nxt == CNT_FULL);
            if (cfg_commit && !cnt_full) begin
                cfg_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_edge_cfg_chain.sv
// Corner switch block: top and left channel outputs driven by shadow-configured 4:1 muxes.
module sb_edge_cfg_chain
    import sb_cfg_pkg::*;
#(
    parameter int unsigned CHAN_W = 9
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              ccff_head,
    input  logic              ccff_en,
    input  logic              cfg_commit,
    input  logic [CHAN_W-1:0] chany_top_in,
    input  logic [CHAN_W-1:0] chanx_left_in,
    input  logic [CHAN_W-1:0] top_pin_in,
    input  logic [CHAN_W-1:0] left_pin_in,
    output logic [CHAN_W-1:0] chany_top_out,
    output logic [CHAN_W-1:0] chanx_left_out,
    output logic              ccff_tail,
    output logic              cfg_ready,
    output logic              cfg_err
);

    localparam int unsigned CHAIN_L = chain_len(CHAN_W);

    logic [CHAIN_L-1:0] sh;

    if (CHAN_W < 2) begin : g_bad_width
        $error("sb_edge_cfg_chain: CHAN_W must be at least 2");
    end

    sb_cfg_chain #(
        .CHAIN_L (CHAIN_L)
    ) u_chain (
        .prog_clk   (prog_clk),
        .prog_reset (prog_reset),
        .ccff_head  (ccff_head),
        .ccff_en    (ccff_en),
        .cfg_commit (cfg_commit),
        .sh         (sh),
        .ccff_tail  (ccff_tail),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err)
    );

    // One mux per output track; top tracks are muxes 0..CHAN_W-1, left tracks follow.
    for (genvar i = 0; i < CHAN_W; i++) begin : g_trk
        localparam int unsigned TW = tw(i, CHAN_W);
        localparam int unsigned MT = i;
        localparam int unsigned ML = CHAN_W + i;

        logic [SEL_W-1:0] sel_top;
        logic [SEL_W-1:0] sel_left;

        assign sel_top  = {sh[2*MT], sh[2*MT+1]};
        assign sel_left = {sh[2*ML], sh[2*ML+1]};

        assign chany_top_out[i]  = mux4(sel_top, top_pin_in[i],
                                        chanx_left_in[TW], chanx_left_in[i]);
        assign chanx_left_out[i] = mux4(sel_left, left_pin_in[i],
                                        chany_top_in[TW], chany_top_in[i]);
    end

endmodule

// File: tb/tb_sb_edge_cfg_chain.sv
// Scoreboard bench for sb_edge_cfg_chain at CHAN_W=9.
module tb_sb_edge_cfg_chain;

    localparam int unsigned W = 9;
    localparam int unsigned L = 36;

    logic         prog_clk = 1'b0;
    logic         prog_reset = 1'b1;
    logic         ccff_head = 1'b0;
    logic         ccff_en = 1'b0;
    logic         cfg_commit = 1'b0;
    logic [W-1:0] chany_top_in = '0;
    logic [W-1:0] chanx_left_in = '0;
    logic [W-1:0] top_pin_in = '0;
    logic [W-1:0] left_pin_in = '0;
    logic [W-1:0] chany_top_out;
    logic [W-1:0] chanx_left_out;
    logic         ccff_tail;
    logic         cfg_ready;
    logic         cfg_err;

    sb_edge_cfg_chain #(.CHAN_W(W)) dut (
        .prog_clk       (prog_clk),
        .prog_reset     (prog_reset),
        .ccff_head      (ccff_head),
        .ccff_en        (ccff_en),
        .cfg_commit     (cfg_commit),
        .chany_top_in   (chany_top_in),
        .chanx_left_in  (chanx_left_in),
        .top_pin_in     (top_pin_in),
        .left_pin_in    (left_pin_in),
        .chany_top_out  (chany_top_out),
        .chanx_left_out (chanx_left_out),
        .ccff_tail      (ccff_tail),
        .cfg_ready      (cfg_ready),
        .cfg_err        (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        string        nm;
        logic [W-1:0] top;
        logic [W-1:0] left;
        logic         tail;
        logic         ready;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err = 0;

    // Reference state of the configuration chain.
    logic [L-1:0] m_sr = '0;
    logic [L-1:0] m_sh = '0;
    int           m_cnt = 0;
    logic         m_err = 1'b0;

    function automatic logic [W-1:0] mdl_out(input logic [L-1:0] s, input int base,
                                             input logic [W-1:0] pin, input logic [W-1:0] opp);
        logic [W-1:0] y;
        logic [1:0]   sel;
        int           j;
        y = '0;
        for (int i = 0; i < W; i++) begin
            j   = base + i;
            sel = {s[2*j], s[2*j+1]};
            case (sel)
                2'b01:   y[i] = pin[i];
                2'b10:   y[i] = opp[(i == 0) ? 0 : W - i];
                2'b11:   y[i] = opp[i];
                default: y[i] = 1'b0;
            endcase
        end
        return y;
    endfunction

    function automatic logic [L-1:0] set_sel(input logic [L-1:0] v, input int j, input logic [1:0] s);
        logic [L-1:0] r;
        r          = v;
        r[2*j]     = s[1];
        r[2*j+1]   = s[0];
        return r;
    endfunction

    task automatic model_edge(input logic head, input logic en, input logic commit);
        if (commit) begin
            if (m_cnt != L) m_err = 1'b1;
            m_sh  = m_sr;
            m_cnt = en ? 1 : 0;
        end else if (en && m_cnt < L) begin
            m_cnt = m_cnt + 1;
        end
        if (en) m_sr = {m_sr[L-2:0], head};
    endtask

    task automatic push_exp(input string nm, input bit hand, input logic [W-1:0] ht,
                            input logic [W-1:0] hl);
        exp_t e;
        e.nm    = nm;
        e.top   = hand ? ht : mdl_out(m_sh, 0, top_pin_in, chanx_left_in);
        e.left  = hand ? hl : mdl_out(m_sh, W, left_pin_in, chany_top_in);
        e.tail  = m_sr[L-1];
        e.ready = (m_cnt == L);
        e.err   = m_err;
        q.push_back(e);
    endtask

    // Apply one clock of stimulus and queue the post-edge expectation.
    task automatic step(input logic head, input logic en, input logic commit, input string nm,
                        input bit hand = 1'b0, input logic [W-1:0] ht = '0,
                        input logic [W-1:0] hl = '0);
        ccff_head  = head;
        ccff_en    = en;
        cfg_commit = commit;
        model_edge(head, en, commit);
        push_exp(nm, hand, ht, hl);
        @(posedge prog_clk);
        @(negedge prog_clk);
        #1;
    endtask

    task automatic load_cfg(input logic [L-1:0] v, input string nm);
        for (int k = L - 1; k >= 0; k--) step(v[k], 1'b1, 1'b0, nm);
    endtask

    task automatic rand_inputs();
        chany_top_in  = W'($urandom);
        chanx_left_in = W'($urandom);
        top_pin_in    = W'($urandom);
        left_pin_in   = W'($urandom);
    endtask

    // Asynchronous reset, held across one edge, with whatever shift/commit inputs are live.
    task automatic do_reset(input string nm);
        prog_reset = 1'b1;
        rand_inputs();
        m_sr  = '0;
        m_sh  = '0;
        m_cnt = 0;
        m_err = 1'b0;
        push_exp(nm, 1'b1, '0, '0);
        @(posedge prog_clk);
        @(negedge prog_clk);
        #1;
        prog_reset = 1'b0;
        ccff_en    = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic chk(input string nm, input string f, input logic [W-1:0] act,
                       input logic [W-1:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s.%s got=%h want=%h", nm, f, act, want);
        end
    endtask

    // Monitor: compare the oldest expectation on each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge prog_clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "top",   chany_top_out,      e.top);
                chk(e.nm, "left",  chanx_left_out,     e.left);
                chk(e.nm, "tail",  W'(ccff_tail),      W'(e.tail));
                chk(e.nm, "ready", W'(cfg_ready),      W'(e.ready));
                chk(e.nm, "err",   W'(cfg_err),        W'(e.err));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [L-1:0] cfg_pin;
        logic [L-1:0] cfg_tw;

        cfg_pin = '0;
        for (int j = 0; j < 2 * W; j++) cfg_pin = set_sel(cfg_pin, j, 2'b01);
        cfg_tw = '0;
        cfg_tw = set_sel(cfg_tw, 1, 2'b10);
        cfg_tw = set_sel(cfg_tw, 2, 2'b11);

        @(negedge prog_clk);
        #1;
        do_reset("reset");

        // All muxes PIN.
        load_cfg(cfg_pin, "pin_load");
        rand_inputs();
        step(1'b0, 1'b0, 1'b1, "pin_commit", 1'b1, top_pin_in, left_pin_in);
        rand_inputs();
        step(1'b0, 1'b0, 1'b0, "pin_comb", 1'b1, top_pin_in, left_pin_in);

        // Shifting new bits leaves the tracks on the committed PIN selects.
        for (int k = 0; k < 20; k++) begin
            step(1'($urandom), 1'b1, 1'b0, "iso_shift", 1'b1, top_pin_in, left_pin_in);
        end

        // Partial commit sets the sticky error.
        do_reset("reset2");
        for (int k = 0; k < 10; k++) step(1'($urandom), 1'b1, 1'b0, "part_shift");
        step(1'b0, 1'b0, 1'b1, "part_commit");

        // Valid load afterwards keeps the error; twist/straight routing.
        load_cfg(cfg_tw, "tw_load");
        step(1'b0, 1'b0, 1'b1, "tw_commit");
        chanx_left_in = 9'h100;
        step(1'b0, 1'b0, 1'b0, "tw_bit8", 1'b1, 9'h002, 9'h000);
        chanx_left_in = 9'h004;
        step(1'b0, 1'b0, 1'b0, "tw_bit2", 1'b1, 9'h004, 9'h000);
        chanx_left_in = 9'h001;
        step(1'b0, 1'b0, 1'b0, "tw_bit0", 1'b1, 9'h000, 9'h000);
        do_reset("reset_clr_err");

        // Commit on the 37th enabled edge captures the first 36 bits.
        load_cfg(cfg_pin, "sim_load");
        rand_inputs();
        step(1'b1, 1'b1, 1'b1, "sim_commit", 1'b1, top_pin_in, left_pin_in);
        step(1'b1, 1'b1, 1'b0, "sim_after");

        // Reset mid-shift and mid-commit.
        ccff_en   = 1'b1;
        ccff_head = 1'b1;
        do_reset("reset_mid_shift");
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, "pre_commit");
        ccff_en    = 1'b1;
        cfg_commit = 1'b1;
        do_reset("reset_mid_commit");
        step(1'b0, 1'b0, 1'b0, "post_reset");

        repeat (2) @(negedge prog_clk);
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
